// File: rtl/twiddle_sequencer_if.sv
// Twiddle output bus between the sequencer (master) and the complex multiplier B operand (slave).
// A beat transfers on a clock edge where o_valid && i_ready; the master holds every field stable while o_valid && !i_ready.
interface twiddle_sequencer_if #(
  parameter int LOG2_N = 6,
  parameter int NB_TW  = 17
);
  logic                     i_ready;
  logic                     o_valid;
  logic signed [NB_TW-1:0]  o_tw_real;
  logic signed [NB_TW-1:0]  o_tw_imag;
  logic [LOG2_N-1:0]        o_stage;
  logic                     o_last;

  modport master (
    input  i_ready,
    output o_valid, o_tw_real, o_tw_imag, o_stage, o_last
  );

  modport slave (
    output i_ready,
    input  o_valid, o_tw_real, o_tw_imag, o_stage, o_last
  );
endinterface

// File: rtl/twiddle_sequencer.sv
// Radix-2 DIF twiddle stream W_N^k, stage-major then butterfly-ascending,
// rebuilt from a quarter-wave cosine ROM and registered behind a valid/ready slot.
module twiddle_sequencer #(
  parameter int N_FFT  = 64,
  parameter int LOG2_N = 6,
  parameter int NB_TW  = 17,
  parameter int NBF_TW = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  twiddle_sequencer_if.master  tw,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [1:0]           o_state
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int                KW    = LOG2_N - 1;
  localparam logic [KW-1:0]     B_MAX = '1;
  localparam logic [KW-1:0]     QTR   = KW'(N_FFT / 4);
  localparam logic [LOG2_N-1:0] S_MAX = LOG2_N'(LOG2_N - 1);

  logic [1:0]               state_q;
  logic [LOG2_N-1:0]        stage_q;
  logic [KW-1:0]            bfly_q;
  logic                     valid_q;
  logic signed [NB_TW-1:0]  re_q;
  logic signed [NB_TW-1:0]  im_q;
  logic [LOG2_N-1:0]        ostage_q;
  logic                     last_q;
  logic                     done_q;

  logic [KW-1:0]            k;
  logic                     k_lo;
  logic [KW-1:0]            re_idx;
  logic [KW-1:0]            im_idx;
  logic signed [NB_TW-1:0]  re_d;
  logic signed [NB_TW-1:0]  im_d;
  logic                     last_d;
  logic                     slot_free;

  // round-half-away(2^NBF_TW * cos(2*pi*m/64)), m = 0..16
  function automatic logic signed [NB_TW-1:0] rom(input logic [KW-1:0] m);
    case (int'(m))
      0:       rom = NB_TW'(1 << NBF_TW);
      1:       rom = NB_TW'(127);
      2:       rom = NB_TW'(126);
      3:       rom = NB_TW'(122);
      4:       rom = NB_TW'(118);
      5:       rom = NB_TW'(113);
      6:       rom = NB_TW'(106);
      7:       rom = NB_TW'(99);
      8:       rom = NB_TW'(91);
      9:       rom = NB_TW'(81);
      10:      rom = NB_TW'(71);
      11:      rom = NB_TW'(60);
      12:      rom = NB_TW'(49);
      13:      rom = NB_TW'(37);
      14:      rom = NB_TW'(25);
      15:      rom = NB_TW'(13);
      default: rom = '0;
    endcase
  endfunction

  always_comb begin
    k      = (bfly_q & (B_MAX >> stage_q)) << stage_q;
    k_lo   = (k < QTR);
    // N/2 - k is the KW-bit two's complement of k, since N/2 = 2^KW
    re_idx = k_lo ? k : (~k + 1'b1);
    im_idx = k_lo ? (QTR - k) : (k - QTR);
    re_d   = k_lo ? rom(re_idx) : -rom(re_idx);
    im_d   = -rom(im_idx);
    last_d = (stage_q == S_MAX) && (bfly_q == B_MAX);
  end

  assign slot_free = !valid_q || tw.i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      bfly_q   <= '0;
      valid_q  <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
      ostage_q <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The o_done cycle already reads as IDLE but must not launch a frame.
          if (i_start && !done_q) begin
            stage_q <= '0;
            bfly_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (slot_free) begin
            re_q     <= re_d;
            im_q     <= im_d;
            ostage_q <= stage_q;
            last_q   <= last_d;
            valid_q  <= 1'b1;
            bfly_q   <= bfly_q + 1'b1;
            if (bfly_q == B_MAX) stage_q <= stage_q + 1'b1;
            if (last_d) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (valid_q && tw.i_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tw.o_valid   = valid_q;
  assign tw.o_tw_real = re_q;
  assign tw.o_tw_imag = im_q;
  assign tw.o_stage   = ostage_q;
  assign tw.o_last    = last_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = done_q;
  assign o_state      = state_q;
endmodule

// File: tb/tb_twiddle_sequencer.sv
// Bench for twiddle_sequencer: golden twiddles from cos/sin arithmetic, random backpressure and start noise.
module tb_twiddle_sequencer;
  localparam int N      = 64;
  localparam int LOG2_N = 6;
  localparam int NB_TW  = 17;
  localparam int NBF_TW = 7;
  localparam int W      = LOG2_N + 2 * NB_TW;
  localparam int BEATS  = LOG2_N * N / 2;
  localparam real PI    = 3.14159265358979;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic       o_busy;
  logic       o_done;
  logic [1:0] o_state;

  twiddle_sequencer_if #(.LOG2_N(LOG2_N), .NB_TW(NB_TW)) tw_if ();

  twiddle_sequencer #(
    .N_FFT(N), .LOG2_N(LOG2_N), .NB_TW(NB_TW), .NBF_TW(NBF_TW)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .tw      (tw_if.master),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_state (o_state)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a[BEATS];

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else return -$rtoi(0.5 - x);
  endfunction

  function automatic logic [W-1:0] pack(input int s, input int re, input int im);
    return {LOG2_N'(s), NB_TW'(re), NB_TW'(im)};
  endfunction

  function automatic logic [W-1:0] cur_beat();
    return {tw_if.o_stage, tw_if.o_tw_real, tw_if.o_tw_imag};
  endfunction

  task automatic fill_expected();
    exp_q.delete();
    for (int s = 0; s < LOG2_N; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        int  k;
        real th;
        k  = (b % (N >> (s + 1))) << s;
        th = 2.0 * PI * real'(k) / real'(N);
        exp_q.push_back(pack(s, rnd(128.0 * $cos(th)), rnd(-128.0 * $sin(th))));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if ({tw_if.o_valid, tw_if.o_tw_real, tw_if.o_tw_imag, tw_if.o_stage, tw_if.o_last, o_busy, o_done} !== '0
        || o_state !== 2'd0) begin
      bad++;
      $display("FAIL %s got valid=%b re=%0d im=%0d stage=%0d last=%b busy=%b done=%b state=%0d want all zero",
               tag, tw_if.o_valid, tw_if.o_tw_real, tw_if.o_tw_imag, tw_if.o_stage, tw_if.o_last,
               o_busy, o_done, o_state);
    end
  endtask

  // Runs one frame from a start pulse; returns accepted beat count and the cycle of first o_valid.
  task automatic run_frame(input int ready_pct, input bit poke, input int abort_beat,
                           input bit hold_start, output int beats, output int first_cyc);
    int           cyc;
    bit           prev_stall;
    bit           expect_done;
    bit           finished;
    logic [W+1:0] prev;
    logic [W-1:0] exp_w;
    beats = 0; first_cyc = -1; cyc = 0;
    prev_stall = 0; expect_done = 0; finished = 0; prev = '0;
    fill_expected();
    @(posedge i_clk); #1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_start got=%b want=1", o_busy);
    end
    while (!finished && cyc < 3000) begin
      if (prev_stall) begin
        total++;
        if ({tw_if.o_valid, tw_if.o_last, cur_beat()} !== prev) begin
          bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, {tw_if.o_valid, tw_if.o_last, cur_beat()}, prev);
        end
      end
      total++;
      if (o_done !== expect_done) begin
        bad++; $display("FAIL done_pulse cyc=%0d got=%b want=%b", cyc, o_done, expect_done);
      end
      if (expect_done) begin
        finished = 1;
      end else begin
        if (tw_if.o_valid && first_cyc < 0) first_cyc = cyc;
        tw_if.i_ready = ($urandom_range(0, 99) < ready_pct);
        if (poke) i_start = ($urandom_range(0, 3) == 0);
        if (hold_start) i_start = 1'b1;
        if (tw_if.o_valid && tw_if.i_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL extra_beat got=%h want=none", cur_beat());
          end else begin
            exp_w = exp_q.pop_front();
            if (cur_beat() !== exp_w) begin
              bad++; $display("FAIL beat_%0d got=%h want=%h", beats, cur_beat(), exp_w);
            end
            total++;
            if (tw_if.o_last !== (exp_q.size() == 0)) begin
              bad++; $display("FAIL last_flag beat=%0d got=%b want=%b", beats, tw_if.o_last, exp_q.size() == 0);
            end
            expect_done = (exp_q.size() == 0);
          end
          if (beats < BEATS) got_a[beats] = cur_beat();
          beats++;
          if (beats == abort_beat) begin
            i_rst = 1'b1;
            i_start = 1'b1;
            @(posedge i_clk); #1;
            check_idle_outputs("reset_mid_frame");
            i_rst = 1'b0;
            i_start = 1'b0;
            tw_if.i_ready = 1'b0;
            return;
          end
        end
        prev_stall = tw_if.o_valid && !tw_if.i_ready;
        prev = {tw_if.o_valid, tw_if.o_last, cur_beat()};
        @(posedge i_clk); #1;
        cyc++;
      end
    end
    if (!finished) begin
      total++; bad++; $display("FAIL frame_timeout beats=%0d want=%0d", beats, BEATS);
    end
    if (!hold_start) i_start = 1'b0;
    tw_if.i_ready = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int beats);
    total++;
    if (beats !== BEATS) begin
      bad++; $display("FAIL %s_count got=%0d want=%0d", tag, beats, BEATS);
    end
  endtask

  task automatic check_got(input string tag, input int idx, input logic [W-1:0] want);
    total++;
    if (got_a[idx] !== want) begin
      bad++; $display("FAIL %s idx=%0d got=%h want=%h", tag, idx, got_a[idx], want);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tw_if.i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_idle_outputs("reset_state");
    i_rst = 1'b0;
  endtask

  task automatic test_basic_frame();
    int beats, first_cyc;
    run_frame(100, 1'b0, -1, 1'b0, beats, first_cyc);
    check_beats("basic", beats);
    total++;
    if (first_cyc !== 1) begin
      bad++; $display("FAIL start_latency got=%0d want=1", first_cyc);
    end
    check_got("first_beat", 0, pack(0, 128, 0));
    check_got("s0_b8", 8, pack(0, 91, -91));
    check_got("s0_b16", 16, pack(0, 0, -128));
    check_got("s0_b24", 24, pack(0, -91, -91));
    check_got("s1_b8", 40, pack(1, 0, -128));
    check_got("s1_b16", 48, pack(1, 128, 0));
    for (int i = 5 * N / 2; i < BEATS; i++) check_got("s5_unity", i, pack(5, 128, 0));
  endtask

  task automatic test_backpressure();
    int beats, first_cyc;
    run_frame(50, 1'b0, -1, 1'b0, beats, first_cyc);
    check_beats("backpressure", beats);
    run_frame(20, 1'b0, -1, 1'b0, beats, first_cyc);
    check_beats("heavy_backpressure", beats);
  endtask

  task automatic test_start_filter();
    int beats, first_cyc;
    run_frame(70, 1'b1, -1, 1'b0, beats, first_cyc);
    check_beats("start_filter", beats);
  endtask

  task automatic test_reset_mid_frame();
    int beats, first_cyc;
    run_frame(80, 1'b0, 50, 1'b0, beats, first_cyc);
    @(posedge i_clk); #1;
    check_idle_outputs("reset_start_ignored");
    run_frame(100, 1'b0, -1, 1'b0, beats, first_cyc);
    check_beats("after_reset", beats);
    check_got("after_reset_first", 0, pack(0, 128, 0));
  endtask

  task automatic test_back_to_back();
    int beats, first_cyc;
    run_frame(100, 1'b0, -1, 1'b1, beats, first_cyc);
    check_beats("b2b_first", beats);
    @(posedge i_clk); #1;
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_state !== 2'd0) begin
      bad++; $display("FAIL b2b_start_in_done got busy=%b state=%0d want busy=0 state=0", o_busy, o_state);
    end
    run_frame(90, 1'b0, -1, 1'b0, beats, first_cyc);
    check_beats("b2b_second", beats);
  endtask

  initial begin
    tw_if.i_ready = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_start_filter();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
